// File: rtl/norm_factor_gen.sv
// Per-frame normalization factor: tracks the frame maximum and computes floor((2^FRAC_WIDTH-1)/max) by restoring division.
// Optional saturating overrun counter port ovr_count when NORM_OVERRUN_CNT_EN is defined.
module norm_factor_gen #(
  parameter int INT_WIDTH  = 8,
  parameter int FRAC_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_valid,
  input  logic [INT_WIDTH-1:0]  pix_data,
  input  logic                  pix_last,
  output logic [FRAC_WIDTH-1:0] norm_factor,
  output logic                  norm_valid,
  output logic                  busy,
  output logic                  overrun
`ifdef NORM_OVERRUN_CNT_EN
  ,
  output logic [15:0]           ovr_count
`endif
);

  localparam int CNT_W = (FRAC_WIDTH > 1) ? $clog2(FRAC_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [INT_WIDTH-1:0]  run_max_q;
  logic [INT_WIDTH-1:0]  frame_max;
  logic                  frame_end;

  logic                  pend_q;
  logic [INT_WIDTH-1:0]  pend_max_q;

  logic                  start;
  logic [INT_WIDTH-1:0]  start_max;

  logic [INT_WIDTH-1:0]  divisor_q;
  logic [INT_WIDTH-1:0]  rem_q;
  logic [INT_WIDTH-1:0]  rem_d;
  logic [INT_WIDTH:0]    trial;
  logic                  ge;
  logic [FRAC_WIDTH-1:0] dq_q;
  logic [CNT_W-1:0]      cnt_q;

  assign frame_end = pix_valid & pix_last;
  assign frame_max = (pix_data > run_max_q) ? pix_data : run_max_q;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_max_q <= '0;
    end else if (pix_valid) begin
      run_max_q <= pix_last ? '0 : frame_max;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A frame end seen in DONE starts the next division immediately; newest frame max wins over a pending one.
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    start_max = pend_max_q;
    case (state_q)
      IDLE: begin
        if (frame_end || pend_q) begin
          start   = 1'b1;
          state_d = DIV;
        end
      end
      DIV: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (frame_end || pend_q) begin
          start   = 1'b1;
          state_d = DIV;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (frame_end) begin
      start_max = frame_max;
    end
  end

  // dq_q starts all-ones: its MSB supplies dividend bits while quotient bits enter at the LSB.
  // A zero divisor therefore yields an all-ones quotient with no special case.
  always_comb begin
    trial = {rem_q, dq_q[FRAC_WIDTH-1]};
    ge    = (trial >= {1'b0, divisor_q});
    rem_d = ge ? INT_WIDTH'(trial - {1'b0, divisor_q}) : INT_WIDTH'(trial);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divisor_q   <= '0;
      rem_q       <= '0;
      dq_q        <= '1;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_max_q  <= '0;
      norm_factor <= '1;
      norm_valid  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      norm_valid <= (state_q == DONE);
      overrun    <= frame_end & pend_q;

      if (state_q == DONE) begin
        norm_factor <= dq_q;
      end

      if (start) begin
        divisor_q <= start_max;
        rem_q     <= '0;
        dq_q      <= '1;
        cnt_q     <= CNT_W'(FRAC_WIDTH - 1);
      end else if (state_q == DIV) begin
        rem_q <= rem_d;
        dq_q  <= {dq_q[FRAC_WIDTH-2:0], ge};
        cnt_q <= cnt_q - CNT_W'(1);
      end

      if (start) begin
        pend_q <= 1'b0;
      end else if (frame_end && (state_q != IDLE)) begin
        pend_q     <= 1'b1;
        pend_max_q <= frame_max;
      end
    end
  end

`ifdef NORM_OVERRUN_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_count <= '0;
    end else if (frame_end && pend_q && (ovr_count != '1)) begin
      ovr_count <= ovr_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_norm_factor_gen.sv
// Directed bench for norm_factor_gen: scoreboard of expected factors and result edges, checked as norm_valid pulses arrive.
module tb_norm_factor_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_data = '0;
  logic       pix_last = 1'b0;
  logic [7:0] norm_factor;
  logic       norm_valid;
  logic       busy;
  logic       overrun;
`ifdef NORM_OVERRUN_CNT_EN
  logic [15:0] ovr_count;
`endif

  norm_factor_gen #(
    .INT_WIDTH (8),
    .FRAC_WIDTH(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_last   (pix_last),
    .norm_factor(norm_factor),
    .norm_valid (norm_valid),
    .busy       (busy),
    .overrun    (overrun)
`ifdef NORM_OVERRUN_CNT_EN
    ,
    .ovr_count  (ovr_count)
`endif
  );

  typedef struct {
    int val;
    int due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_start = -1;
  int   last_due = -1;
  bit   have_job = 1'b0;
  int   exp_ovr = 0;
  int   ovr_seen = 0;
  int   tb_run = 0;
  int   exp_nf = 255;

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int qexp(input int m);
    return (m == 0) ? 255 : 255 / m;
  endfunction

  // Expected result edge: a new frame end starts at its own edge if the divider is free
  // (or in its DONE cycle), else it waits for the current result edge; a second waiting one replaces the first.
  task automatic note_frame_end(input int m);
    int   c;
    int   s;
    exp_t e;
    c = cyc + 1;
    if (have_job && last_start >= c) begin
      e = sb.pop_back();
      e.val = qexp(m);
      sb.push_back(e);
      exp_ovr++;
    end else begin
      s = (have_job && c < last_due) ? last_due : c;
      e.val = qexp(m);
      e.due = s + 9;
      sb.push_back(e);
      last_start = s;
      last_due   = s + 9;
      have_job   = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (overrun === 1'b1) ovr_seen++;
      if (norm_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("spurious_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("norm_factor", norm_factor, e.val);
          chk("result_edge", cyc, e.due);
          exp_nf = e.val;
        end
      end else begin
        chk("hold", norm_factor, exp_nf);
      end
    end
  end

  task automatic beat(input int d, input bit last);
    int m;
    @(negedge clk);
    pix_valid = 1'b1;
    pix_data  = 8'(d);
    pix_last  = last;
    m = (d > tb_run) ? d : tb_run;
    if (last) begin
      tb_run = 0;
      note_frame_end(m);
    end else begin
      tb_run = m;
    end
  endtask

  task automatic step();
    @(negedge clk);
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    pix_data  = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) step();
    chk("drain_empty", sb.size(), 0);
    repeat (2) step();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    have_job = 1'b0;
    tb_run   = 0;
    exp_nf   = 255;
    #1;
    chk("rst_norm_factor", norm_factor, 255);
    chk("rst_norm_valid", norm_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    // {3,200,17}: 255/200 = 1, busy for exactly 9 cycles
    beat(3, 0);
    beat(200, 0);
    beat(17, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("busy_window", busy, (i < 9) ? 1 : 0);
    end
    drain();

    beat(0, 0);
    beat(0, 1);
    drain();
    beat(255, 1);
    drain();
    beat(1, 1);
    drain();
    beat(4, 0);
    beat(16, 0);
    beat(9, 1);
    drain();

    // second frame ends 3 cycles after the first: queued, no overrun
    beat(50, 1);
    step();
    step();
    beat(5, 1);
    drain();
    chk("no_overrun", ovr_seen, exp_ovr);

    // three frame ends inside one division: middle one is overwritten
    beat(10, 1);
    step();
    beat(20, 1);
    step();
    beat(40, 1);
    drain();
    chk("overrun_count", ovr_seen, exp_ovr);
`ifdef NORM_OVERRUN_CNT_EN
    chk("ovr_count", ovr_count, 1);
`endif

    // reset during a division aborts it
    beat(100, 1);
    repeat (4) step();
    do_reset();
    repeat (12) step();
    beat(85, 1);
    drain();

    // frame end in the DONE cycle goes straight back to DIV
    beat(30, 1);
    repeat (8) step();
    beat(7, 1);
    step();
    chk("done_to_div_busy", busy, 1);
    drain();
    chk("overrun_final", ovr_seen, exp_ovr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/norm_factor_gen.md
NORM_FACTOR_GEN -- requirements
Module: norm_factor_gen

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  INT_WIDTH  8  pixel width (unsigned integer)
  FRAC_WIDTH  8  norm_factor width (unsigned fraction, LSB = 2^-FRAC_WIDTH)
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock, rising edge
  rst  in  1  asynchronous, active-high reset
  pix_valid  in  1  pixel beat present
  pix_data  in  INT_WIDTH  pixel value
  pix_last  in  1  final pixel of frame; qualified by pix_valid
  norm_factor  out  FRAC_WIDTH  current normalization factor, held between updates
  norm_valid  out  1  one-cycle pulse: norm_factor just updated
  busy  out  1  division in progress
  overrun  out  1  one-cycle pulse: frame end arrived while a request was already pending
REQ-003 The block SHALL use one clock (clk) and an asynchronous, active-high reset (rst).

Function
REQ-004 Every pix_valid beat SHALL be accepted; the block SHALL NOT have a backpressure output.
REQ-005 The running maximum SHALL update to max(running, pix_data) on each beat with pix_valid=1 and pix_last=0.
REQ-006 On a beat with pix_valid=1 and pix_last=1, frame_max SHALL be max(running, pix_data), and running SHALL clear to 0 on the same edge.
REQ-007 The quotient SHALL be Q = floor((2^FRAC_WIDTH - 1) / frame_max) for frame_max >= 1, and Q = 2^FRAC_WIDTH - 1 for frame_max = 0.
  - This guarantees frame_max*Q < 2^FRAC_WIDTH, so the downstream multiplier output is < 1.
REQ-008 The quotient SHALL be computed by restoring division, one bit per cycle, over FRAC_WIDTH iterations; no combinational divider is permitted.
REQ-009 The FSM SHALL have states IDLE, DIV, DONE.
  - IDLE -> DIV on a frame-end beat, or on a set pending flag; loads dividend, divisor and iteration counter = FRAC_WIDTH-1.
  - DIV -> DONE when the counter reaches 0 after its iteration.
  - DONE -> IDLE (or DIV if pending) after one cycle.
REQ-010 Latency SHALL be fixed: frame-end beat sampled at edge k -> norm_factor updated and norm_valid=1 for exactly one cycle after edge k+FRAC_WIDTH+1.
REQ-011 busy SHALL be 1 in DIV and DONE, and 0 in IDLE.
REQ-012 A frame end arriving while not IDLE SHALL store frame_max in a one-deep pending register; its division SHALL start on the edge that leaves DONE.
REQ-013 A frame end arriving while pending is already set SHALL overwrite the pending value (newest wins) and pulse overrun for one cycle.
REQ-014 A frame end coinciding with the DONE cycle SHALL be treated as pending; the FSM SHALL go DONE -> DIV with no IDLE cycle.
REQ-015 norm_factor SHALL change only on the norm_valid edge and SHALL hold its value otherwise.

Reset
REQ-016 On rst assertion the block SHALL immediately set: norm_factor = 2^FRAC_WIDTH-1, norm_valid=0, busy=0, overrun=0, state=IDLE, running max=0, pending cleared.
REQ-017 rst asserted mid-division SHALL abort the division with no norm_valid pulse; after release the block SHALL wait for a new frame end.

Configuration
REQ-018 With NORM_OVERRUN_CNT_EN defined, the block SHALL add port ovr_count  out  16: a saturating count of overrun pulses, reset to 0, holding at 16'hFFFF.
REQ-019 Without NORM_OVERRUN_CNT_EN, port ovr_count and its logic SHALL be absent; the overrun pulse SHALL be unchanged.

Verification (INT_WIDTH=8, FRAC_WIDTH=8)
REQ-020 Frame of pixels {3,200,17}, last on 17 -> norm_factor=1 (255/200) with norm_valid exactly 9 cycles after the last edge; busy high for 9 cycles.
REQ-021 Frame of all zeros -> norm_factor=255; frame max 255 -> norm_factor=1; frame max 1 -> norm_factor=255; frame max 16 -> norm_factor=15.
REQ-022 Second frame (max 5) ends 3 cycles after the first (max 50) -> norm_factor=5 then norm_factor=51; two norm_valid pulses; second pulse 9 cycles after the first pulse's DONE exit; no overrun.
REQ-023 Three frame ends (maxes 10, 20, 40) within one division -> results 25 then 6; overrun pulsed once; ovr_count=1 when macro defined.
REQ-024 rst pulsed 4 cycles into a division -> no norm_valid, norm_factor=255, busy=0; next frame (max 85) -> norm_factor=3.
REQ-025 Frame-end beat in the DONE cycle -> DONE->DIV directly; next result lands FRAC_WIDTH+1 cycles after DONE.
